// File: rtl/bcd_time_editor.sv
// bcd_time_editor: push-button editor for a 4-digit BCD MM:SS word (optional auto-repeat: AUTO_REPEAT_EN)
module bcd_time_editor #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] load_value,
   input  logic        push_u,
   input  logic        push_d,
   input  logic        push_l,
   input  logic        push_r,
   input  logic        push_m,
   output logic [15:0] num,
   output logic [3:0]  sel,
   output logic        finish,
   output logic        editing
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int U  = 0;
   localparam int DN = 1;
   localparam int L  = 2;
   localparam int R  = 3;
   localparam int M  = 4;

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("REPEAT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, EDIT, DONE} state_t;

   state_t          state_q, state_d;
   logic [15:0]     num_q, num_d;
   logic [3:0]      sel_q, sel_d;
   logic            fin_q, fin_d;
   logic            edit_q, edit_d;
   logic [4:0]      sync1_q, sync1_d;
   logic [4:0]      sync2_q, sync2_d;
   logic [4:0]      lvl_q, lvl_d;
   logic [4:0]      prev_q, prev_d;
   logic [CW-1:0]   cnt_q [5];
   logic [CW-1:0]   cnt_d [5];
   logic [4:0]      press;
   logic [4:0]      ev;
   logic [1:0]      pos;
   logic [3:0]      dig, lim, dig_up, dig_dn;

   // per-button sync, stability count and debounced level; events are debounced rising edges
   always_comb begin
      sync1_d = {push_m, push_r, push_l, push_d, push_u};
      sync2_d = sync1_q;
      prev_d  = lvl_q;
      lvl_d   = lvl_q;
      press   = lvl_q & ~prev_q;
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = (sync2_q[i] == lvl_q[i]) ? '0 : cnt_q[i] + CW'(1);
         if (sync2_q[i] != lvl_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            lvl_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end
      end
   end

   // debouncer state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         prev_q  <= '0;
         cnt_q   <= '{default: '0};
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         lvl_q   <= lvl_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES);
   logic [RW-1:0] rep_q, rep_d;
   logic          held, rep_fire;

   // repeat timer runs while u or d stays held in EDIT; any action or leaving EDIT restarts it
   always_comb begin
      held     = lvl_q[U] | lvl_q[DN];
      rep_fire = (state_q == EDIT) && held && (rep_q == RW'(REPEAT_CYCLES - 1));
      ev       = press | {3'b000, rep_fire & ~lvl_q[U] & lvl_q[DN], rep_fire & lvl_q[U]};
      rep_d    = (state_q != EDIT || !enable || !held || |ev) ? '0 : rep_q + RW'(1);
   end

   // repeat timer register
   always_ff @(posedge clk) begin
      rep_q <= reset ? '0 : rep_d;
   end
`else
   // one action per press
   always_comb begin
      ev = press;
   end
`endif

   // session FSM next state: abort beats commit beats up/down/left/right
   always_comb begin
      pos     = ~sel_q[3] ? 2'd3 : ~sel_q[2] ? 2'd2 : ~sel_q[1] ? 2'd1 : 2'd0;
      dig     = num_q[{pos, 2'b00} +: 4];
      lim     = pos[0] ? 4'd5 : 4'd9;
      dig_up  = (dig >= lim) ? 4'd0 : dig + 4'd1;
      dig_dn  = (dig == 4'd0 || dig > lim) ? lim : dig - 4'd1;
      state_d = state_q;
      num_d   = num_q;
      sel_d   = sel_q;
      fin_d   = 1'b0;
      edit_d  = edit_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = EDIT;
               num_d   = load_value;
               sel_d   = 4'b0111;
               edit_d  = 1'b1;
            end
         end
         EDIT: begin
            if (!enable) begin
               state_d = IDLE;
               sel_d   = 4'b1111;
               edit_d  = 1'b0;
            end else if (ev[M]) begin
               state_d = DONE;
               sel_d   = 4'b1111;
               edit_d  = 1'b0;
               fin_d   = 1'b1;
            end else if (ev[U]) begin
               num_d[{pos, 2'b00} +: 4] = dig_up;
            end else if (ev[DN]) begin
               num_d[{pos, 2'b00} +: 4] = dig_dn;
            end else if (ev[L]) begin
               sel_d = {sel_q[2:0], sel_q[3]};
            end else if (ev[R]) begin
               sel_d = {sel_q[0], sel_q[3:1]};
            end
         end
         DONE: begin
            state_d = enable ? DONE : IDLE;
         end
         default: begin
            state_d = IDLE;
            sel_d   = 4'b1111;
            edit_d  = 1'b0;
         end
      endcase
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         num_q   <= '0;
         sel_q   <= 4'b1111;
         fin_q   <= 1'b0;
         edit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         sel_q   <= sel_d;
         fin_q   <= fin_d;
         edit_q  <= edit_d;
      end
   end

   // output wiring
   always_comb begin
      num     = num_q;
      sel     = sel_q;
      finish  = fin_q;
      editing = edit_q;
   end
endmodule

// File: tb/tb_bcd_time_editor.sv
// tb_bcd_time_editor: randomized bench checked every cycle against a digit/cursor reference model
module tb_bcd_time_editor;
   localparam int D = 4;
   localparam logic [4:0] BU = 5'b00001;
   localparam logic [4:0] BD = 5'b00010;
   localparam logic [4:0] BL = 5'b00100;
   localparam logic [4:0] BR = 5'b01000;
   localparam logic [4:0] BM = 5'b10000;

   logic        clk = 1'b0;
   logic        reset, enable;
   logic [15:0] load_value;
   logic        push_u, push_d, push_l, push_r, push_m;
   logic [15:0] num;
   logic [3:0]  sel;
   logic        finish, editing;
   int          n_cmp = 0;
   int          n_err = 0;

   bit          h [5][D+1];
   bit          lv [5];
   bit          rose [5];
   int          st;
   int          dg [4];
   int          pos;
   bit          m_fin;
   int          hc [5];

   always #5 clk = ~clk;

   bcd_time_editor #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(4096)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load_value(load_value),
      .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r), .push_m(push_m),
      .num(num), .sel(sel), .finish(finish), .editing(editing)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [4:0] m);
      {push_m, push_r, push_l, push_d, push_u} = m;
   endtask

   // reference: a button level flips once the last D synchronized samples all disagree with it
   task automatic ref_step();
      bit raw [5];
      bit ev [5];
      bit flip;
      int mx;
      raw = '{push_u, push_d, push_l, push_r, push_m};
      if (reset) begin
         for (int b = 0; b < 5; b++) begin
            for (int j = 0; j <= D; j++) h[b][j] = 0;
            lv[b] = 0;
            rose[b] = 0;
         end
         for (int i = 0; i < 4; i++) dg[i] = 0;
         st = 0;
         pos = 3;
         m_fin = 0;
         return;
      end
      for (int b = 0; b < 5; b++) begin
         ev[b] = rose[b];
         flip = 1;
         for (int j = 1; j <= D; j++) if (h[b][j] == lv[b]) flip = 0;
         rose[b] = flip && !lv[b];
         if (flip) lv[b] = !lv[b];
         for (int j = D; j > 0; j--) h[b][j] = h[b][j-1];
         h[b][0] = raw[b];
      end
      m_fin = 0;
      mx = (pos % 2 == 1) ? 5 : 9;
      if (st == 0) begin
         if (enable) begin
            st = 1;
            pos = 3;
            for (int i = 0; i < 4; i++) dg[i] = int'((load_value >> (4 * i)) & 16'hF);
         end
      end else if (st == 1) begin
         if (!enable) st = 0;
         else if (ev[4]) begin st = 2; m_fin = 1; end
         else if (ev[0]) dg[pos] = (dg[pos] + 1 > mx) ? 0 : dg[pos] + 1;
         else if (ev[1]) dg[pos] = (dg[pos] == 0 || dg[pos] > mx) ? mx : dg[pos] - 1;
         else if (ev[2]) pos = (pos + 1) % 4;
         else if (ev[3]) pos = (pos + 3) % 4;
      end else if (!enable) st = 0;
   endtask

   task automatic tick();
      logic [15:0] exp_num;
      logic [3:0]  oh, exp_sel;
      @(posedge clk);
      ref_step();
      #1;
      exp_num = 16'((dg[3] << 12) | (dg[2] << 8) | (dg[1] << 4) | dg[0]);
      oh = 4'b0001 << pos;
      exp_sel = (st == 1) ? ~oh : 4'hF;
      check("num", num, exp_num);
      check("sel", sel, exp_sel);
      check("finish", finish, m_fin);
      check("editing", editing, st == 1);
   endtask

   task automatic hold(input logic [4:0] m, input int n_on, input int n_off);
      for (int i = 0; i < n_on + n_off; i++) begin
         drive(i < n_on ? m : 5'b0);
         tick();
      end
   endtask

   logic [4:0]  seq_m [9]  = '{BL, BU, BL, BU, BD, BR, BR, BR, BR};
   logic [15:0] seq_n [9]  = '{16'h1559, 16'h1550, 16'h1550, 16'h1500, 16'h1550,
                               16'h1550, 16'h1550, 16'h1550, 16'h1550};
   logic [3:0]  seq_s [9]  = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101,
                               4'b1110, 4'b0111, 4'b1011, 4'b1101};
   logic [4:0]  rm;

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      load_value = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         drive(5'($urandom));
         tick();
      end
      check("rst_num", num, 16'h0000);
      check("rst_sel", sel, 4'b1111);
      check("rst_finish", finish, 1'b0);
      check("rst_editing", editing, 1'b0);
      reset = 1'b0;
      hold(5'b0, 0, 8);

      load_value = 16'h0559;
      enable = 1'b1;
      tick();
      check("start_num", num, 16'h0559);
      check("start_sel", sel, 4'b0111);
      for (int i = 1; i <= 10; i++) begin
         drive(BU);
         tick();
         check("u_latency", num, i >= 7 ? 16'h1559 : 16'h0559);
      end
      hold(5'b0, 0, 8);

      for (int k = 0; k < 9; k++) begin
         hold(seq_m[k], 6, 8);
         check("seq_num", num, seq_n[k]);
         check("seq_sel", sel, seq_s[k]);
      end

      hold(BU, 3, 10);
      for (int i = 0; i < 20; i++) begin
         drive(i % 2 == 1 ? BU : 5'b0);
         tick();
      end
      hold(5'b0, 0, 10);
      check("glitch_num", num, 16'h1550);

      for (int i = 1; i <= 14; i++) begin
         drive(i <= 6 ? (BU | BM) : 5'b0);
         tick();
         check("commit_fin", finish, i == 7);
      end
      check("done_num", num, 16'h1550);
      check("done_editing", editing, 1'b0);
      enable = 1'b0;
      tick();
      check("idle_sel", sel, 4'b1111);

      load_value = 16'h1234;
      enable = 1'b1;
      tick();
      hold(BU, 6, 8);
      check("edit2_num", num, 16'h2234);
      enable = 1'b0;
      tick();
      check("abort_finish", finish, 1'b0);
      check("abort_num", num, 16'h2234);
      check("abort_sel", sel, 4'b1111);

      for (int b = 0; b < 5; b++) hc[b] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 5; b++) begin
            if (hc[b] > 0) hc[b]--;
            else if ($urandom_range(0, 24) == 0) hc[b] = $urandom_range(1, 12);
            rm[b] = (hc[b] > 0) ^ ($urandom_range(0, 49) == 0);
         end
         drive(rm);
         if ($urandom_range(0, 79) == 0) enable = ~enable;
         reset = ($urandom_range(0, 1499) == 0);
         load_value = 16'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
